// File: rtl/mc_recon.sv
// mc_recon: motion-compensated 4x4 block fetch from a streamed 8x8 reference area.
//   A two-cycle motion vector (x then y, signed 3-bit) selects the block origin
//   (row 2-y, col x+2). Only the 16 pixels inside the block are kept while the
//   64-pixel area streams in. The block is then emitted row-major over 16 cycles.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   vec_valid, vec_in  - motion vector component strobe / value
//   area_valid, in_data- reference area pixel strobe / value (raster order)
//   out_valid, out_data- predicted block pixel strobe / value (registered)
// Build option: define MC_CLAMP_EN to clamp out-of-range vector components to
//   +/-2; by default they are replaced by 0.
module mc_recon (
  input  logic       clk,
  input  logic       rst,
  input  logic       vec_valid,
  input  logic [2:0] vec_in,
  input  logic       area_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data
);

  localparam int unsigned VW   = 3;
  localparam int unsigned PW   = 8;
  localparam int unsigned KW   = 6;
  localparam int unsigned CW   = 4;
  localparam int unsigned NBLK = 16;

  typedef enum logic [2:0] {IDLE, VEC_Y, WAIT_AREA, LOAD, OUT} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   x_q, x_d;
  logic [VW-1:0]   y_q, y_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_data_q, out_data_d;
  logic [PW-1:0]   blk_q [NBLK];

  logic [VW-1:0]   r0, c0, row, col, dr, dc;
  logic            in_blk;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;
  logic [CW-1:0]   cnt_nxt;

  // Legal components (-2..2) pass through; -4, -3 and 3 are fixed up.
  function automatic logic [VW-1:0] fix_comp(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    case (v)
`ifdef MC_CLAMP_EN
      3'b011:         r = 3'b010;
      3'b100, 3'b101: r = 3'b110;
`else
      3'b011, 3'b100, 3'b101: r = '0;
`endif
      default:        r = v;
    endcase
    return r;
  endfunction

  // Block window test for the current pixel index; modulo-8 arithmetic is
  // exact because the origin never exceeds 4.
  always_comb begin
    r0      = VW'(3'd2 - y_q);
    c0      = VW'(x_q + 3'd2);
    row     = k_q[5:3];
    col     = k_q[2:0];
    dr      = VW'(row - r0);
    dc      = VW'(col - c0);
    in_blk  = (row >= r0) && (dr < 3'd4) && (col >= c0) && (dc < 3'd4);
    wr_idx  = {dr[1:0], dc[1:0]};
    cnt_nxt = CW'(cnt_q + 4'd1);
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (vec_valid) begin
          x_d     = fix_comp(vec_in);
          state_d = VEC_Y;
        end
      end
      VEC_Y: begin
        if (vec_valid) begin
          y_d     = fix_comp(vec_in);
          state_d = WAIT_AREA;
        end else begin
          x_d     = '0;
          state_d = IDLE;
        end
      end
      WAIT_AREA, LOAD: begin
        // k is 0 in WAIT_AREA, so the first pixel lands as pixel 0.
        if (area_valid) begin
          wr_en   = in_blk;
          k_d     = KW'(k_q + 6'd1);
          state_d = LOAD;
          if (k_q == 6'd63) begin
            // Block origin is captured well before pixel 63, so blk_q[0] is final.
            state_d     = OUT;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = blk_q[0];
          end
        end
      end
      OUT: begin
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d       = cnt_nxt;
          out_valid_d = 1'b1;
          out_data_d  = blk_q[cnt_nxt];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Block storage; always rewritten in full before being read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      blk_q[wr_idx] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/mc_recon.md
MC_RECON -- requirements
Module: mc_recon

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port vec_valid, input, 1, high on the two consecutive cycles that carry a motion vector.
REQ-004 SHALL have port vec_in, input, 3, signed vector component: x on the first vec_valid cycle, y on the second.
REQ-005 SHALL have port area_valid, input, 1, qualifies in_data as one 8x8 reference-area pixel.
REQ-006 SHALL have port in_data, input, 8, unsigned area pixel, raster order (row 0 col 0 first, col fastest).
REQ-007 SHALL have port out_valid, output, 1, qualifies out_data.
REQ-008 SHALL have port out_data, output, 8, predicted 4x4 block pixel, raster order.

Function
REQ-009 SHALL implement states IDLE, VEC_Y, WAIT_AREA, LOAD, OUT.
REQ-010 IDLE: vec_valid=1 latches vec_in as x and moves to VEC_Y; area_valid is ignored in IDLE.
REQ-011 VEC_Y: vec_valid=1 latches vec_in as y and moves to WAIT_AREA; vec_valid=0 discards x and returns to IDLE.
REQ-012 Block origin: row r0 = 2 - y, column c0 = x + 2, using the legal range x,y in -2..2, so that (-2,2) maps to origin (0,0) and (2,-2) maps to origin (4,4).
REQ-013 WAIT_AREA: the first area_valid cycle moves to LOAD and counts as pixel 0.
REQ-014 LOAD: a 6-bit pixel counter k advances only on area_valid cycles; area_valid gaps hold k and all state.
REQ-015 A pixel SHALL be stored only if row = k[5:3] is in r0..r0+3 and column = k[2:0] is in c0..c0+3, giving 16 bytes of storage with no full-frame buffer.
REQ-016 On capture of pixel 63, the FSM SHALL enter OUT on the next cycle.
REQ-017 OUT: out_valid=1 for exactly 16 consecutive cycles, and out_data carries the stored block row-major starting at (r0,c0); the first out_valid comes one cycle after pixel 63 is captured.
REQ-018 After the 16th output, the FSM SHALL return to IDLE, out_valid=0, and out_data=0.
REQ-019 Outside OUT, out_data SHALL be 0 and out_valid SHALL be 0.
REQ-020 vec_valid and area_valid SHALL be ignored during OUT, and vec_valid SHALL be ignored during WAIT_AREA and LOAD.
REQ-021 A vector arriving on the cycle after the last output SHALL be accepted normally (back-to-back operation).
REQ-022 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, counters=0, latched x/y=0, out_valid=0, and out_data=0 at any point, including mid-LOAD or mid-OUT.
REQ-024 Stored block bytes need not be cleared, but they SHALL never be presented before being rewritten.
REQ-025 The first vector SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-026 With macro MC_CLAMP_EN defined, out-of-range components (-4, -3, 3) SHALL be clamped to -2 or +2 at latch time.
REQ-027 Without MC_CLAMP_EN, an out-of-range component SHALL be replaced by 0 at latch time.
REQ-028 In both configurations, legal values SHALL be unchanged and port lists SHALL be identical.

Verification
REQ-029 Area pixel value = 8*row+col, vector (0,0) -> 16 outputs 18,19,20,21,26..29,34..37,42..45, starting one cycle after pixel 63.
REQ-030 Same area, vectors (-2,2) then (2,-2) back-to-back -> 0..3,8..11,16..19,24..27, then 36..39,44..47,52..55,60..63.
REQ-031 Vector (3,-4) -> with MC_CLAMP_EN, outputs equal those for (2,-2); without it, outputs equal those for (0,0).
REQ-032 Vector (1,-1) with area_valid deasserted for 3 cycles after pixels 10 and 40 -> outputs 27..30,35..38,43..46,51..54, with first out_valid delayed by exactly 6 cycles.
REQ-033 rst pulsed during the 5th output cycle -> out_valid=0 and out_data=0 the same cycle; a single vec_valid cycle (x only) then area stream -> no output.
REQ-034 area_valid stream sent in IDLE without a vector -> no out_valid; a vector sent during OUT -> ignored, with no second block produced.
